// File: rtl/loop_sequencer_pkg.sv
// loop_sequencer_pkg: shared widths and FSM encoding for the loop sequencer and decoder.
package loop_sequencer_pkg;
  localparam int LOOP_ID_W = 5;
  localparam int LOOP_ITER_W = 16;
  localparam int NUM_LEVELS = 1 << LOOP_ID_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/loop_sequencer_if.sv
// loop_sequencer_if: decoder config/control and datapath step handshake.
interface loop_sequencer_if;
  import loop_sequencer_pkg::*;
  logic                   cfg_loop_iter_v;
  logic [LOOP_ITER_W-1:0] cfg_loop_iter;
  logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id;
  logic                   start;
  logic                   done;
  logic                   stall;
  logic                   iter_v;
  logic [LOOP_ID_W-1:0]   iter_loop_id;
  logic                   iter_first;
  logic                   iter_last;
  logic                   busy;
  modport master (
    output cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id, start, stall,
    input  done, iter_v, iter_loop_id, iter_first, iter_last, busy
  );
  modport slave (
    input  cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id, start, stall,
    output done, iter_v, iter_loop_id, iter_first, iter_last, busy
  );
endinterface

// File: rtl/loop_level_counter.sv
// loop_level_counter: trip-count limit and running counter for one loop level.
module loop_level_counter
  import loop_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [LOOP_ITER_W-1:0] wr_val,
  input  logic                   inc,
  input  logic                   clr_cnt,
  input  logic                   clr_all,
  output logic                   at_max,
  output logic                   cnt_zero
);
  logic [LOOP_ITER_W-1:0] max_q, max_d, cnt_q, cnt_d;
  always_comb begin
    max_d = clr_all ? '0 : wr_en ? wr_val : max_q;
    cnt_d = (clr_all || clr_cnt) ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end
  assign at_max   = cnt_q == max_q;
  assign cnt_zero = cnt_q == '0;
endmodule

// File: rtl/loop_sequencer.sv
// loop_sequencer: walks a configured loop nest one step per accepted handshake.
module loop_sequencer
  import loop_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  loop_sequencer_if.slave  bus
);
  logic [1:0]            rst_pipe_q;
  logic                  rst_n;
  state_e                state_q, state_d;
  logic [LOOP_ID_W-1:0]  iter_loop_id_q, iter_loop_id_d;
  logic [LOOP_ID_W:0]    num_loops_q, num_loops_d, cfg_depth;
  logic [NUM_LEVELS-1:0] at_max, cnt_zero, at_eff, wr_en, inc, clr_cnt;
  logic [LOOP_ID_W-1:0]  lo;
  logic                  found, idle, step, last, take_start, clr_all;
  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe_q <= '0;
    else rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end
  assign rst_n      = rst_pipe_q[1];
  assign idle       = state_q == IDLE;
  assign step       = state_q == RUN && !bus.stall;
  assign take_start = idle && bus.start;
  assign clr_all    = state_q == DONE;
  assign last       = &at_eff;
  assign cfg_depth  = {1'b0, bus.cfg_loop_iter_loop_id} + 1'b1;
  // Levels outside the configured nest count as permanently at their limit.
  always_comb begin
    found = 1'b0;
    lo    = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      at_eff[i] = at_max[i] || ((LOOP_ID_W+1)'(i) >= num_loops_q);
      if (!found && !at_eff[i]) begin
        found = 1'b1;
        lo    = LOOP_ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_LEVELS; i++) begin
      wr_en[i]   = idle && bus.cfg_loop_iter_v && bus.cfg_loop_iter_loop_id == LOOP_ID_W'(i);
      inc[i]     = step && !last && lo == LOOP_ID_W'(i);
      clr_cnt[i] = take_start || (step && !last && LOOP_ID_W'(i) < lo);
    end
  end
  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_lvl
    loop_level_counter u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[g]),
      .wr_val   (bus.cfg_loop_iter),
      .inc      (inc[g]),
      .clr_cnt  (clr_cnt[g]),
      .clr_all  (clr_all),
      .at_max   (at_max[g]),
      .cnt_zero (cnt_zero[g])
    );
  end
  always_comb begin
    state_d = take_start ? RUN
            : (step && last) ? DONE
            : clr_all ? IDLE
            : state_q;
    iter_loop_id_d = (take_start || (step && last)) ? '0
                   : step ? lo
                   : iter_loop_id_q;
    num_loops_d = clr_all ? '0
                : (idle && bus.cfg_loop_iter_v && cfg_depth > num_loops_q) ? cfg_depth
                : num_loops_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      iter_loop_id_q <= '0;
      num_loops_q    <= '0;
    end else begin
      state_q        <= state_d;
      iter_loop_id_q <= iter_loop_id_d;
      num_loops_q    <= num_loops_d;
    end
  end
  assign bus.iter_v       = state_q == RUN;
  assign bus.done         = clr_all;
  assign bus.busy         = !idle;
  assign bus.iter_loop_id = iter_loop_id_q;
  assign bus.iter_first   = bus.iter_v && &cnt_zero;
  assign bus.iter_last    = bus.iter_v && last;
endmodule
